button_conditioner: RTL
=======================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1000000, number of consecutive stable synchronized samples required to accept a level change; legal range 2..2^20-1.
REQ-002 Parameter CNT_W, default 20, width of the debounce counter; SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-003 clock  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-005 btn_in  input  1  raw, asynchronous, bouncing pushbutton level (1 = pressed).
REQ-006 btn_level  output  1  debounced button level, registered.
REQ-007 btn_pulse  output  1  single-cycle press strobe, registered; drives the ain input of the downstream pulse-counting FSM.
REQ-008 press_count  output  8  count of accepted presses, registered.

Function
REQ-009 btn_in SHALL pass through a two-flop synchronizer; btn_sync (the second flop) SHALL be the only internal use of btn_in.
REQ-010 The FSM SHALL have exactly four states: IDLE (stable low), CONFIRM_HIGH, PRESSED (stable high), CONFIRM_LOW.
REQ-011 IDLE: btn_sync=1 -> CONFIRM_HIGH with counter cleared to 0; else remain.
REQ-012 CONFIRM_HIGH: btn_sync=0 -> IDLE, counter cleared; btn_sync=1 and counter=DEBOUNCE_CYCLES-1 -> PRESSED, counter cleared; otherwise counter increments by 1.
REQ-013 PRESSED: btn_sync=0 -> CONFIRM_LOW with counter cleared to 0; else remain.
REQ-014 CONFIRM_LOW: btn_sync=1 -> PRESSED, counter cleared; btn_sync=0 and counter=DEBOUNCE_CYCLES-1 -> IDLE, counter cleared; otherwise counter increments by 1.
REQ-015 Undefined state encodings SHALL return to IDLE on the next edge with counter cleared.
REQ-016 btn_level SHALL be 1 while the state is PRESSED or CONFIRM_LOW, 0 otherwise.
REQ-017 btn_pulse SHALL be 1 for exactly the one cycle in which the state first becomes PRESSED from CONFIRM_HIGH; a CONFIRM_LOW->PRESSED return SHALL NOT pulse.
REQ-018 Latency: if btn_in is first sampled high at edge k and stays high, the state SHALL be CONFIRM_HIGH after edge k+2 and PRESSED, with btn_pulse=1, after edge k+2+DEBOUNCE_CYCLES.
REQ-019 Release SHALL take the symmetric latency, k+2+DEBOUNCE_CYCLES, to reach IDLE and drive btn_level=0; release SHALL produce no pulse.
REQ-020 press_count SHALL increment by 1 on the same edge that asserts btn_pulse; it SHALL wrap 255 -> 0.
REQ-021 Any glitch shorter than DEBOUNCE_CYCLES synchronized samples SHALL leave btn_level, btn_pulse and press_count unchanged.
REQ-022 The counter SHALL never exceed DEBOUNCE_CYCLES-1.
REQ-023 Holding the button indefinitely SHALL yield exactly one btn_pulse.

Reset
REQ-024 While reset=1 at a rising edge: state=IDLE, counter=0, both synchronizer flops=0, btn_level=0, btn_pulse=0, press_count=0.
REQ-025 Reset SHALL take priority over all transitions, including a reset asserted mid-CONFIRM_HIGH or in the same cycle a pulse would fire; that pulse SHALL be suppressed and press_count SHALL not increment.
REQ-026 After reset deasserts with btn_in held high, the full REQ-018 sequence SHALL be required before a pulse.

Verification (DEBOUNCE_CYCLES=4)
REQ-027 Reset then btn_in=1 from edge 10 -> btn_pulse=1 only in the cycle after edge 16; btn_level=1 from edge 16; press_count=1.
REQ-028 btn_in toggling 1,0,1,0 every 2 cycles for 20 cycles, then 0 -> btn_level, btn_pulse and press_count remain 0 throughout.
REQ-029 Clean press held 50 cycles, then release -> one pulse; btn_level falls 6 cycles after btn_in falls; press_count=1.
REQ-030 256 clean press/release cycles -> 256 single-cycle pulses; press_count ends at 0 (wrap).
REQ-031 Press, then reset asserted 1 cycle before the expected pulse edge -> no pulse, press_count=0, btn_level=0; after release, state=IDLE.
REQ-032 While PRESSED, a 2-cycle low glitch -> btn_level stays 1 and no extra pulse occurs.

Source files
------------

// File: rtl/button_conditioner.sv
// button_conditioner
//   Conditions a raw, bouncing pushbutton into a clean debounced level, a
//   single-cycle press strobe and a running press counter.
//
//   The raw input first passes through a two-flop synchronizer. A four-state
//   FSM then accepts a level change only after DEBOUNCE_CYCLES consecutive
//   agreeing synchronized samples.
//
// Ports
//   clock        in   1  single clock, rising-edge active
//   reset        in   1  synchronous active-high reset
//   btn_in       in   1  raw asynchronous button level (1 = pressed)
//   btn_level    out  1  debounced level, registered
//   btn_pulse    out  1  one-cycle strobe on each accepted press, registered
//   press_count  out  8  number of accepted presses, wraps 255 -> 0
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       btn_in,
  output logic       btn_level,
  output logic       btn_pulse,
  output logic [7:0] press_count
);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    CONFIRM_HIGH = 2'd1,
    PRESSED      = 2'd2,
    CONFIRM_LOW  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] count;
  logic             sync_p0;
  logic             btn_sync;

  // Synchronizer: btn_sync is the only internal consumer of btn_in.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0  <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      sync_p0  <= btn_in;
      btn_sync <= sync_p0;
    end
  end

  // Debounce FSM with registered outputs. Each CONFIRM state counts agreeing
  // samples; a disagreeing sample falls back to the stable state it came from.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      btn_level   <= 1'b0;
      btn_pulse   <= 1'b0;
      press_count <= 8'd0;
    end else begin
      btn_pulse <= 1'b0;
      case (state)
        IDLE: begin
          btn_level <= 1'b0;
          if (btn_sync) begin
            state <= CONFIRM_HIGH;
            count <= '0;
          end
        end
        CONFIRM_HIGH: begin
          if (!btn_sync) begin
            state     <= IDLE;
            count     <= '0;
            btn_level <= 1'b0;
          end else if (count == CNT_LAST) begin
            // The only path that produces a press strobe.
            state       <= PRESSED;
            count       <= '0;
            btn_level   <= 1'b1;
            btn_pulse   <= 1'b1;
            press_count <= press_count + 8'd1;
          end else begin
            count     <= count + CNT_ONE;
            btn_level <= 1'b0;
          end
        end
        PRESSED: begin
          btn_level <= 1'b1;
          if (!btn_sync) begin
            state <= CONFIRM_LOW;
            count <= '0;
          end
        end
        CONFIRM_LOW: begin
          if (btn_sync) begin
            // Bounce during release: return to PRESSED without a strobe.
            state     <= PRESSED;
            count     <= '0;
            btn_level <= 1'b1;
          end else if (count == CNT_LAST) begin
            state     <= IDLE;
            count     <= '0;
            btn_level <= 1'b0;
          end else begin
            count     <= count + CNT_ONE;
            btn_level <= 1'b1;
          end
        end
        default: begin
          state     <= IDLE;
          count     <= '0;
          btn_level <= 1'b0;
        end
      endcase
    end
  end

endmodule
